// File: rtl/bus_arbiter.sv
// Shares one external memory bus between instruction fetch and data access.
// Data has fixed priority; each transfer is latched at grant and ends on slave ack or timeout.
module bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifetch_req,
    input  logic [ADDR_W-1:0]   ifetch_addr,
    output logic [DATA_W-1:0]   ifetch_rdata,
    output logic                ifetch_ack,
    output logic                ifetch_err,
    input  logic                dmem_req,
    input  logic                dmem_we,
    input  logic [DATA_W/8-1:0] dmem_sel,
    input  logic [ADDR_W-1:0]   dmem_addr,
    input  logic [DATA_W-1:0]   dmem_wdata,
    output logic [DATA_W-1:0]   dmem_rdata,
    output logic                dmem_ack,
    output logic                dmem_err,
    output logic                bus_req,
    output logic                bus_we,
    output logic [DATA_W/8-1:0] bus_sel,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_ack,
    output logic                stallreq_from_bus
);

    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY, ACK} state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             owner_d;
    logic             err_flag;
    logic             busy;
    logic             timeout;
    logic             grant_d;
    logic             grant_if;

    assign busy     = (state == IF_BUSY) || (state == D_BUSY);
    assign timeout  = (wait_cnt == CNT_W'(MAX_WAIT - 1));
    assign grant_d  = (state == IDLE) && dmem_req;
    assign grant_if = (state == IDLE) && !dmem_req && ifetch_req;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: next_state gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (dmem_req)        next_state = D_BUSY;
                else if (ifetch_req) next_state = IF_BUSY;
            end
            IF_BUSY, D_BUSY: begin
                if (bus_ack || timeout) next_state = ACK;
            end
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bus fields are captured once at grant and left untouched until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_sel      <= '0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            wait_cnt     <= '0;
            owner_d      <= 1'b0;
            err_flag     <= 1'b0;
            ifetch_rdata <= '0;
            dmem_rdata   <= '0;
        end else if (grant_d) begin
            bus_req   <= 1'b1;
            bus_we    <= dmem_we;
            bus_sel   <= dmem_sel;
            bus_addr  <= dmem_addr;
            bus_wdata <= dmem_wdata;
            wait_cnt  <= '0;
            owner_d   <= 1'b1;
            err_flag  <= 1'b0;
        end else if (grant_if) begin
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_sel   <= {SEL_W{1'b1}};
            bus_addr  <= ifetch_addr;
            bus_wdata <= '0;
            wait_cnt  <= '0;
            owner_d   <= 1'b0;
            err_flag  <= 1'b0;
        end else if (busy) begin
            if (bus_ack) begin
                bus_req <= 1'b0;
                if (owner_d) dmem_rdata   <= bus_we ? '0 : bus_rdata;
                else         ifetch_rdata <= bus_rdata;
            end else if (timeout) begin
                // Abort: an ack on this same edge would have taken the branch above.
                bus_req  <= 1'b0;
                err_flag <= 1'b1;
                if (owner_d) dmem_rdata   <= '0;
                else         ifetch_rdata <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        ifetch_ack = (state == ACK) && !owner_d;
        dmem_ack   = (state == ACK) && owner_d;
        ifetch_err = ifetch_ack && err_flag;
        dmem_err   = dmem_ack && err_flag;
        stallreq_from_bus = (ifetch_req && !ifetch_ack) || (dmem_req && !dmem_ack);
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter: a transaction-level schedule model predicts every
// bus cycle, ack pulse, error flag and read-data value of each scenario.
module tb_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifetch_req;
    logic [AW-1:0] ifetch_addr;
    logic [DW-1:0] ifetch_rdata;
    logic          ifetch_ack;
    logic          ifetch_err;
    logic          dmem_req;
    logic          dmem_we;
    logic [SW-1:0] dmem_sel;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ack;
    logic          dmem_err;
    logic          bus_req;
    logic          bus_we;
    logic [SW-1:0] bus_sel;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;
    logic          bus_ack;
    logic          stallreq_from_bus;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] exp_if_rdata;
    logic [DW-1:0] exp_d_rdata;

    bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr), .ifetch_rdata(ifetch_rdata),
        .ifetch_ack(ifetch_ack), .ifetch_err(ifetch_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_sel(dmem_sel), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .dmem_err(dmem_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .stallreq_from_bus(stallreq_from_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One scenario: optional data transfer (granted first) and optional fetch, both
    // requested at cycle 0 and held through their own ack cycle. A transfer whose slave
    // inserts w wait states occupies the bus for min(w+1, MW) cycles; its ack follows.
    // d_we: 0 load, 1 store, 2 random.
    task automatic run_scenario(input bit use_d, input bit use_if, input int wd, input int wi,
                                input int d_we);
        int            nt;
        int            s[2], len[2], ak[2], w[2];
        bit            is_d[2];
        logic          we_k[2];
        logic [SW-1:0] sel_k[2];
        logic [AW-1:0] addr_k[2];
        logic [DW-1:0] wdat_k[2], sdata[2];
        int            ad, ai, cur, last;
        logic          e_breq, e_iack, e_ierr, e_dack, e_derr;
        nt = 0; ad = -1; ai = -1;
        if (use_d)  begin is_d[nt] = 1'b1; w[nt] = wd; nt++; end
        if (use_if) begin is_d[nt] = 1'b0; w[nt] = wi; nt++; end
        for (int k = 0; k < nt; k++) begin
            len[k]   = (w[k] + 1 < MW) ? w[k] + 1 : MW;
            s[k]     = (k == 0) ? 0 : ak[k-1] + 1;
            ak[k]    = s[k] + len[k] + 1;
            sdata[k] = $urandom;
            if (is_d[k]) ad = ak[k];
            else         ai = ak[k];
        end
        last = ak[nt-1] + 1;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            dmem_req    = use_d && (c <= ad);
            ifetch_req  = use_if && (c <= ai);
            dmem_we     = (d_we == 2) ? 1'($urandom_range(0, 1)) : 1'(d_we);
            dmem_sel    = SW'($urandom);
            dmem_addr   = $urandom;
            dmem_wdata  = $urandom;
            ifetch_addr = $urandom;
            bus_rdata   = $urandom;
            e_breq = 1'b0; e_iack = 1'b0; e_ierr = 1'b0; e_dack = 1'b0; e_derr = 1'b0;
            cur = -1;
            for (int k = 0; k < nt; k++) begin
                if (c == s[k]) begin
                    we_k[k]   = is_d[k] ? dmem_we    : 1'b0;
                    sel_k[k]  = is_d[k] ? dmem_sel   : {SW{1'b1}};
                    addr_k[k] = is_d[k] ? dmem_addr  : ifetch_addr;
                    wdat_k[k] = is_d[k] ? dmem_wdata : '0;
                end
                if (c >= s[k] + 1 && c <= s[k] + len[k]) begin
                    e_breq = 1'b1;
                    cur = k;
                end
                if (c == ak[k]) begin
                    if (is_d[k]) begin
                        e_dack = 1'b1;
                        e_derr = (w[k] >= MW);
                        exp_d_rdata = (e_derr || we_k[k]) ? '0 : sdata[k];
                    end else begin
                        e_iack = 1'b1;
                        e_ierr = (w[k] >= MW);
                        exp_if_rdata = e_ierr ? '0 : sdata[k];
                    end
                end
            end
            if (cur >= 0) begin
                bus_ack = (c == s[cur] + w[cur] + 1);
                if (bus_ack) bus_rdata = sdata[cur];
            end else begin
                // Spurious acks with no transfer outstanding must be ignored.
                bus_ack = ($urandom_range(0, 3) == 0);
            end
            #1;
            check("bus_req", 64'(bus_req), 64'(e_breq));
            if (cur >= 0) begin
                check("bus_we",    64'(bus_we),    64'(we_k[cur]));
                check("bus_sel",   64'(bus_sel),   64'(sel_k[cur]));
                check("bus_addr",  64'(bus_addr),  64'(addr_k[cur]));
                check("bus_wdata", 64'(bus_wdata), 64'(wdat_k[cur]));
            end
            check("ifetch_ack",   64'(ifetch_ack),   64'(e_iack));
            check("ifetch_err",   64'(ifetch_err),   64'(e_ierr));
            check("dmem_ack",     64'(dmem_ack),     64'(e_dack));
            check("dmem_err",     64'(dmem_err),     64'(e_derr));
            check("ifetch_rdata", 64'(ifetch_rdata), 64'(exp_if_rdata));
            check("dmem_rdata",   64'(dmem_rdata),   64'(exp_d_rdata));
            check("stall", 64'(stallreq_from_bus),
                  64'((ifetch_req & ~e_iack) | (dmem_req & ~e_dack)));
        end
    endtask

    initial begin
        rst = 1'b1;
        ifetch_req = 1'b0; ifetch_addr = '0;
        dmem_req = 1'b0; dmem_we = 1'b0; dmem_sel = '0; dmem_addr = '0; dmem_wdata = '0;
        bus_rdata = '0; bus_ack = 1'b0;
        exp_if_rdata = '0; exp_d_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_bus_req", 64'(bus_req), 64'd0);
        check("rst_acks", 64'({ifetch_ack, dmem_ack, ifetch_err, dmem_err}), 64'd0);
        check("rst_rdata", 64'({ifetch_rdata, dmem_rdata}), 64'd0);
        check("rst_stall", 64'(stallreq_from_bus), 64'd0);
        rst = 1'b0;

        run_scenario(1'b0, 1'b1, 0, 0, 2);     // zero-wait fetch
        run_scenario(1'b1, 1'b1, 0, 0, 1);     // simultaneous: store first, then fetch
        run_scenario(1'b1, 1'b0, 3, 0, 0);     // load, 3 wait states (ack on last legal edge)
        run_scenario(1'b1, 1'b0, 100, 0, 0);   // slave never acks: timeout
        run_scenario(1'b0, 1'b1, MW, 0, 2);    // fetch timeout
        run_scenario(1'b1, 1'b1, MW - 1, MW, 2);
        for (int i = 0; i < 40; i++) begin
            bit ud, ui;
            ud = 1'($urandom_range(0, 1));
            ui = ud ? 1'($urandom_range(0, 1)) : 1'b1;
            run_scenario(ud, ui, $urandom_range(0, MW + 1), $urandom_range(0, MW + 1), 2);
        end

        // Asynchronous reset while a load is on the bus.
        @(negedge clk);
        dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h100; ifetch_req = 1'b0; bus_ack = 1'b0;
        @(negedge clk);
        check("pre_rst_bus_req", 64'(bus_req), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_bus_req", 64'(bus_req), 64'd0);
        check("async_rst_acks", 64'({ifetch_ack, dmem_ack, ifetch_err, dmem_err}), 64'd0);
        check("async_rst_rdata", 64'({ifetch_rdata, dmem_rdata}), 64'd0);
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        run_scenario(1'b1, 1'b0, 1, 0, 0);     // pending load re-granted from IDLE
        run_scenario(1'b1, 1'b1, 2, 1, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
